// File: rtl/avr_spi_io_master.sv
`timescale 1ns/1ps
// SPI (mode 0) slave front end that turns each chip-select framed transaction into one IO-bus read or write.
// Latency: IO access starts 1 clk after grant once the command (read) or data byte (write) is complete; read data appears on miso at capture.
// Backpressure: bus_req is held until bus_gnt; a read that is not granted before byte 1 starts is aborted and returns 0xFF.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_sck/cs_n/mosi   SPI host inputs, asynchronous to clk, synchronised internally
//   spi_miso            serial read data, MSB first, changes after sck falling edges
//   bus_req / bus_gnt   IO bus ownership handshake with the top-level arbiter
//   io_addr, io_data    IO address and bidirectional data (driven only during a write access)
//   io_read, io_write   single-cycle access strobes
module avr_spi_io_master #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [5:0] io_addr,
    inout  wire  [7:0] io_data,
    output logic       io_read,
    output logic       io_write
);

    typedef enum logic [2:0] {
        IDLE, CMD, WDATA, REQ, ACC, RDATA, WAIT_CS
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [SYNC_STAGES-1:0] vld_sr;     // marks when the synchronisers hold real samples
    logic                   sck_d;
    logic                   armed;      // cs_n has been seen high since reset
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_sr;
    logic [7:0]             tx_sr;
    logic                   cmd_wr;
    logic [5:0]             cmd_addr;
    logic [7:0]             wdata;
    logic                   data_oe;

    logic       sck_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       last_bit;
    logic [7:0] rx_byte;

    assign sck_s    = sck_sr[SYNC_STAGES-1];
    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign mosi_s   = mosi_sr[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign last_bit = (bit_cnt == 3'd7);
    assign rx_byte  = {rx_sr, mosi_s};

    assign io_data = data_oe ? wdata : 8'bzzzz_zzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sck_sr   <= '0;
            cs_sr    <= '1;
            mosi_sr  <= '0;
            vld_sr   <= '0;
            sck_d    <= 1'b0;
            armed    <= 1'b0;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 8'd0;
            cmd_wr   <= 1'b0;
            cmd_addr <= 6'd0;
            wdata    <= 8'd0;
            data_oe  <= 1'b0;
            spi_miso <= 1'b0;
            bus_req  <= 1'b0;
            io_addr  <= 6'd0;
            io_read  <= 1'b0;
            io_write <= 1'b0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            vld_sr  <= {vld_sr[SYNC_STAGES-2:0], 1'b1};
            sck_d   <= sck_s;
            // The reset preset of the cs_n chain must not look like a real
            // high level, otherwise a frame in flight at reset release would
            // be mistaken for a fresh cs_n falling edge.
            if (vld_sr[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;

            // cs_n high ends the frame from any active state; an access
            // strobe already on the bus is allowed to finish its cycle.
            if (state != IDLE && state != ACC && cs_s) begin
                state    <= IDLE;
                bus_req  <= 1'b0;
                spi_miso <= 1'b0;
                bit_cnt  <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        // armed implies cs_n was high while in IDLE, so a low
                        // level here is a falling edge.
                        if (armed && !cs_s) begin
                            state   <= CMD;
                            bit_cnt <= 3'd0;
                            rx_sr   <= 7'd0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                cmd_wr   <= rx_byte[7];
                                cmd_addr <= rx_byte[5:0];
                                spi_miso <= 1'b1;
                                if (rx_byte[6]) begin
                                    state <= WAIT_CS;
                                end else if (rx_byte[7]) begin
                                    state <= WDATA;
                                end else begin
                                    state   <= REQ;
                                    bus_req <= 1'b1;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                wdata   <= rx_byte;
                                state   <= REQ;
                                bus_req <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        // For a read the bit counter is 0 here, so any rising
                        // edge is the first bit of byte 1: too late to fetch.
                        if (!cmd_wr && sck_rise) begin
                            bus_req <= 1'b0;
                            state   <= WAIT_CS;
                        end else if (bus_gnt) begin
                            state    <= ACC;
                            io_addr  <= cmd_addr;
                            io_write <= cmd_wr;
                            io_read  <= ~cmd_wr;
                            data_oe  <= cmd_wr;
                        end
                    end
                    ACC: begin
                        io_read  <= 1'b0;
                        io_write <= 1'b0;
                        io_addr  <= 6'd0;
                        data_oe  <= 1'b0;
                        bus_req  <= 1'b0;
                        if (!cmd_wr) begin
                            // Bit 7 goes out at once: the falling edge that
                            // would normally present it may already be past.
                            spi_miso <= io_data[7];
                            tx_sr    <= {io_data[6:0], 1'b1};
                            state    <= RDATA;
                        end else begin
                            state <= WAIT_CS;
                        end
                    end
                    RDATA: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                state    <= WAIT_CS;
                                spi_miso <= 1'b1;
                            end
                        end else if (sck_fall && bit_cnt != 3'd0) begin
                            // Only falling edges inside byte 1 shift; the one
                            // closing byte 0 must not skip bit 7.
                            spi_miso <= tx_sr[7];
                            tx_sr    <= {tx_sr[6:0], 1'b1};
                        end
                    end
                    WAIT_CS: begin
                        spi_miso <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
